// File: rtl/regfile_scoreboard.sv
// Architectural register file with two combinational read ports, write-to-read
// bypass, per-register pending bits and a self-clearing sequencer after reset.
module regfile_scoreboard #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 5,
  parameter bit                ZERO_REG   = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              pend_a,
  output logic              pend_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NPORT = 2;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [DEPTH-1:0]  pend_reg;
  logic [DEPTH-1:0]  pend_next;
  logic [DATA_W-1:0] mem [DEPTH];

  logic run;
  logic wr_ok;
  logic rsv_ok;

  assign run       = (state_reg == RUN);
  assign init_busy = (state_reg == INIT);

  // Register 0 is never written nor reserved when it is hardwired to zero.
  assign wr_ok  = run && wr_en  && !(ZERO_REG && (wr_addr  == '0));
  assign rsv_ok = run && rsv_en && !(ZERO_REG && (rsv_addr == '0));

  // Reserve is applied after release so a same-cycle new producer wins.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
    assign pend_next[gi] = (rsv_ok && (rsv_addr == ADDR_W'(gi))) ? 1'b1 :
                           (wr_ok  && (wr_addr  == ADDR_W'(gi))) ? 1'b0 :
                           pend_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= INIT;
      ptr_reg   <= '0;
      pend_reg  <= '0;
    end else if (state_reg == INIT) begin
      ptr_reg <= ptr_reg + ADDR_W'(1);
      if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
        state_reg <= RUN;
      end
    end else begin
      pend_reg <= pend_next;
    end
  end

  // Storage has no reset; the sequencer sweeps it while the state is INIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_reg == INIT) begin
        mem[ptr_reg] <= INIT_VALUE;
      end else if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  logic [ADDR_W-1:0] port_addr [NPORT];
  logic [DATA_W-1:0] port_data [NPORT];
  logic [NPORT-1:0]  port_pend;

  assign port_addr[0] = rd_addr_a;
  assign port_addr[1] = rd_addr_b;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_rd
    logic zero_hit;
    logic byp_hit;

    assign zero_hit = ZERO_REG && (port_addr[gi] == '0);
    assign byp_hit  = wr_en && (wr_addr == port_addr[gi]);

    assign port_data[gi] = !run     ? '0 :
                           zero_hit ? '0 :
                           byp_hit  ? wr_data :
                           mem[port_addr[gi]];

    // A same-cycle write releases the register before the edge.
    assign port_pend[gi] = run && pend_reg[port_addr[gi]] && !byp_hit;
  end

  assign rd_data_a = port_data[0];
  assign rd_data_b = port_data[1];
  assign pend_a    = port_pend[0];
  assign pend_b    = port_pend[1];

endmodule
